// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from the transmit FIFO and sends them LSB first.
// Frame is start, 8 data bits, optional even parity, stop; tx_int is held per frame.
module uart_tx #(
  parameter int BIT_CYCLES = 16,
  parameter bit PARITY_EN  = 1'b1
) (
  input  logic       clk_uart,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] txd_from_fifo,
  output logic       r_en,
  output logic       txd,
  output logic       tx_busy,
  input  logic       tx_int_clr,
  output logic       tx_int
);
  // state  | meaning
  // IDLE   | line high, waiting for tx_en with a non-empty FIFO
  // FETCH  | one-cycle FIFO pop (r_en)
  // LOAD   | capture FIFO data and its parity
  // START  | start bit, line low
  // DATA   | data bits d0..d7, LSB first
  // PARITY | even parity bit
  // STOP   | stop bit, line high; sets tx_int on exit

  localparam int              CW       = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic          r_txd;
  logic          r_tx_int;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    w_idx_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_parity_nxt;
  logic          w_txd_nxt;
  logic          w_bit_end;
  logic          w_int_set;

  assign w_bit_end = (r_cnt == '0);
  assign w_int_set = (r_state == S_STOP) && w_bit_end;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;
    case (r_state)
      S_IDLE: begin
        if (tx_en && !fifo_empty) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_shift_nxt  = txd_from_fifo;
        w_parity_nxt = ^txd_from_fifo;
        w_cnt_nxt    = CNT_LOAD;
        w_idx_nxt    = 3'd0;
        w_state_nxt  = S_START;
      end
      S_START: begin
        if (w_bit_end) begin
          w_cnt_nxt   = CNT_LOAD;
          w_idx_nxt   = 3'd0;
          w_state_nxt = S_DATA;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt   = CNT_LOAD;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_idx == 3'd7) begin
            w_idx_nxt   = 3'd0;
            w_state_nxt = PARITY_EN ? S_PARITY : S_STOP;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = S_STOP;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Line value follows the state being entered, so each bit appears on the same edge as its state.
  always_comb begin
    w_txd_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_txd_nxt = 1'b0;
      S_DATA:   w_txd_nxt = w_shift_nxt[0];
      S_PARITY: w_txd_nxt = w_parity_nxt;
      default:  w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk_uart) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= 3'd0;
      r_shift  <= 8'h00;
      r_parity <= 1'b0;
      r_txd    <= 1'b1;
      r_tx_int <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_shift  <= w_shift_nxt;
      r_parity <= w_parity_nxt;
      r_txd    <= w_txd_nxt;
      if (w_int_set)       r_tx_int <= 1'b1;
      else if (tx_int_clr) r_tx_int <= 1'b0;
    end
  end

  assign r_en    = (r_state == S_FETCH);
  assign tx_busy = (r_state != S_IDLE);
  assign txd     = r_txd;
  assign tx_int  = r_tx_int;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: default instance (16 cycles/bit, parity) fed by a FIFO model,
// plus a PARITY_EN=0, BIT_CYCLES=4 instance.
module tb_uart_tx;
  logic       clk_uart = 1'b0;
  logic       rst_n;
  logic       tx_en;
  logic       r_en;
  logic       txd;
  logic       tx_busy;
  logic       tx_int_clr;
  logic       tx_int;
  logic       fifo_empty;
  logic [7:0] fifo_dout = 8'h00;

  logic       tx_en_np;
  logic       fifo_empty_np;
  logic [7:0] din_np;
  logic       r_en_np;
  logic       txd_np;
  logic       tx_busy_np;
  logic       tx_int_np;

  logic [7:0] fifo_mem [0:15];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         ren_cnt = 0;
  int         n_cmp = 0;
  int         n_mis = 0;

  logic       rx_on = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_par;
  logic       rx_stop;
  logic [9:0] rx_q [$];

  always #5 clk_uart = ~clk_uart;

  uart_tx u_dut (
    .clk_uart      (clk_uart),
    .rst_n         (rst_n),
    .tx_en         (tx_en),
    .fifo_empty    (fifo_empty),
    .txd_from_fifo (fifo_dout),
    .r_en          (r_en),
    .txd           (txd),
    .tx_busy       (tx_busy),
    .tx_int_clr    (tx_int_clr),
    .tx_int        (tx_int)
  );

  uart_tx #(.BIT_CYCLES(4), .PARITY_EN(1'b0)) u_dut_np (
    .clk_uart      (clk_uart),
    .rst_n         (rst_n),
    .tx_en         (tx_en_np),
    .fifo_empty    (fifo_empty_np),
    .txd_from_fifo (din_np),
    .r_en          (r_en_np),
    .txd           (txd_np),
    .tx_busy       (tx_busy_np),
    .tx_int_clr    (1'b0),
    .tx_int        (tx_int_np)
  );

  // FIFO model: read data valid the cycle after r_en
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk_uart) begin
    if (r_en) begin
      fifo_dout <= fifo_mem[rd_ptr % 16];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  always @(posedge clk_uart) begin
    if (r_en) ren_cnt <= ren_cnt + 1;
  end

  // Receiver model: mid-bit sampling after the start edge
  initial begin
    forever begin
      @(negedge clk_uart);
      if (rx_on && txd === 1'b0) begin
        repeat (8) @(negedge clk_uart);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk_uart);
          rx_byte[i] = txd;
        end
        repeat (16) @(negedge clk_uart);
        rx_par = txd;
        repeat (16) @(negedge clk_uart);
        rx_stop = txd;
        rx_q.push_back({rx_stop, (rx_par == ^rx_byte), rx_byte});
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_mem[wr_ptr % 16] = b;
    wr_ptr++;
  endtask

  // Entered at the negedge of cycle t (IDLE, start condition true); returns at t+179.
  task automatic frame_check(input logic [10:0] exp_f, input bit clr_at_set, input string tag);
    check_val({tag, "_t_txd"}, txd, 1);
    check_val({tag, "_t_busy"}, tx_busy, 0);
    @(negedge clk_uart);
    check_val({tag, "_t1_ren"}, r_en, 1);
    check_val({tag, "_t1_busy"}, tx_busy, 1);
    check_val({tag, "_t1_txd"}, txd, 1);
    @(negedge clk_uart);
    check_val({tag, "_t2_ren"}, r_en, 0);
    check_val({tag, "_t2_txd"}, txd, 1);
    for (int k = 0; k < 11; k++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clk_uart);
        check_val($sformatf("%s_bit%0d_c%0d", tag, k, c), txd, exp_f[k]);
      end
    end
    if (clr_at_set) begin
      check_val({tag, "_int_before"}, tx_int, 0);
      tx_int_clr = 1'b1;
    end
    @(negedge clk_uart);
    tx_int_clr = 1'b0;
    check_val({tag, "_int_set"}, tx_int, 1);
    check_val({tag, "_end_busy"}, tx_busy, 0);
    check_val({tag, "_end_txd"}, txd, 1);
  endtask

  task automatic idle_window(input int n, input string tag);
    int n_ren;
    int n_busy;
    int n_low;
    n_ren = 0; n_busy = 0; n_low = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_uart);
      if (r_en !== 1'b0) n_ren++;
      if (tx_busy !== 1'b0) n_busy++;
      if (txd !== 1'b1) n_low++;
    end
    check_val({tag, "_ren_cycles"}, n_ren, 0);
    check_val({tag, "_busy_cycles"}, n_busy, 0);
    check_val({tag, "_txd_low_cycles"}, n_low, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int ren0;
    logic [9:0] ent;
    logic [7:0] lb [0:2];
    logic [10:0] np_f;
    rst_n = 1'b0; tx_en = 1'b0; tx_int_clr = 1'b0;
    tx_en_np = 1'b0; fifo_empty_np = 1'b1; din_np = 8'h81;
    repeat (3) @(negedge clk_uart);
    check_val("rst_txd", txd, 1);
    check_val("rst_ren", r_en, 0);
    check_val("rst_busy", tx_busy, 0);
    check_val("rst_int", tx_int, 0);
    check_val("rst_np_txd", txd_np, 1);
    check_val("rst_np_int", tx_int_np, 0);
    rst_n = 1'b1;
    @(negedge clk_uart);

    // single byte 0xA5: start 0, data 1,0,1,0,0,1,0,1, parity 0, stop 1
    push_byte(8'hA5);
    tx_en = 1'b1;
    frame_check(11'b1_0_10100101_0, 1'b0, "a5");
    repeat (20) @(negedge clk_uart);
    check_val("a5_int_held", tx_int, 1);

    // loopback 0x3C, 0xFF, 0x00 back-to-back
    lb[0] = 8'h3C; lb[1] = 8'hFF; lb[2] = 8'h00;
    push_byte(8'h3C); push_byte(8'hFF); push_byte(8'h00);
    rx_on = 1'b1;
    ren0 = ren_cnt;
    frame_check(11'b1_0_00111100_0, 1'b0, "lb3c");
    frame_check(11'b1_0_11111111_0, 1'b0, "lbff");
    frame_check(11'b1_0_00000000_0, 1'b0, "lb00");
    repeat (5) @(negedge clk_uart);
    rx_on = 1'b0;
    check_val("lb_ren_pulses", ren_cnt - ren0, 3);
    check_val("lb_rx_count", rx_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (rx_q.size() > 0) ent = rx_q.pop_front();
      else ent = 10'h000;
      check_val($sformatf("lb_rx%0d", i), ent, {2'b11, lb[i]});
    end

    // empty FIFO with tx_en=1, then tx_en=0 with data waiting
    idle_window(250, "empty");
    tx_en = 1'b0;
    push_byte(8'h07);
    idle_window(250, "txen0");

    // tx_en dropped mid-frame: 0x07 completes, 0xC3 stays queued
    push_byte(8'hC3);
    tx_en = 1'b1;
    fork
      frame_check(11'b1_1_00000111_0, 1'b0, "mid07");
      begin
        repeat (50) @(negedge clk_uart);
        tx_en = 1'b0;
      end
    join
    idle_window(200, "after_mid");
    check_val("after_mid_fifo_level", wr_ptr - rd_ptr, 1);

    // reset during data bit 3 of 0xC3 (d3 = 0)
    tx_en = 1'b1;
    ren0 = ren_cnt;
    @(negedge clk_uart);
    check_val("rst_mid_t1_ren", r_en, 1);
    repeat (69) @(negedge clk_uart);
    check_val("rst_mid_d3", txd, 0);
    rst_n = 1'b0;
    @(negedge clk_uart);
    rst_n = 1'b1;
    check_val("rst_mid_txd", txd, 1);
    check_val("rst_mid_busy", tx_busy, 0);
    check_val("rst_mid_int", tx_int, 0);
    check_val("rst_mid_ren", r_en, 0);
    idle_window(50, "post_rst");
    check_val("post_rst_ren_total", ren_cnt - ren0, 1);

    // clean frame after reset, with clear coinciding with set
    push_byte(8'h5A);
    frame_check(11'b1_0_01011010_0, 1'b1, "hs5a");
    repeat (5) @(negedge clk_uart);
    check_val("hs_int_held", tx_int, 1);
    tx_int_clr = 1'b1;
    @(negedge clk_uart);
    tx_int_clr = 1'b0;
    check_val("hs_int_cleared", tx_int, 0);
    repeat (3) @(negedge clk_uart);
    check_val("hs_int_stays_clear", tx_int, 0);

    // PARITY_EN=0, BIT_CYCLES=4, byte 0x81: 0, 1,0,0,0,0,0,0,1, 1
    np_f = {1'b0, 10'b1_10000001_0};
    fifo_empty_np = 1'b0;
    tx_en_np = 1'b1;
    @(negedge clk_uart);
    check_val("np_t1_ren", r_en_np, 1);
    fifo_empty_np = 1'b1;
    @(negedge clk_uart);
    check_val("np_t2_ren", r_en_np, 0);
    check_val("np_t2_txd", txd_np, 1);
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk_uart);
        check_val($sformatf("np_bit%0d_c%0d", k, c), txd_np, np_f[k]);
      end
    end
    check_val("np_int_t42", tx_int_np, 0);
    @(negedge clk_uart);
    check_val("np_int_t43", tx_int_np, 1);
    check_val("np_busy_t43", tx_busy_np, 0);
    repeat (10) @(negedge clk_uart);
    check_val("np_no_refetch", r_en_np, 0);
    check_val("np_txd_idle", txd_np, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
